hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage in-order core. Detects load-use
//   hazards and branch/jump redirects from the execute stage, and (optionally)
//   holds the pipeline while a multi-cycle mul/div unit computes.
//
//   Optional feature macro: HAZARD_MULDIV_EN
//     defined   -> ex_is_md launches the multi-cycle unit and the FSM waits in
//                  MD_WAIT until md_done.
//     undefined -> ex_is_md and md_done are ignored, md_start/md_busy stay 0
//                  and the FSM never leaves RUN. All ports remain present.
//
//   Parameters
//     CNT_W        width of the performance counters (default 32)
//
//   Ports
//     clk          sole clock, rising-edge
//     rst          synchronous active-high reset
//     id_*         decode-stage instruction: valid, source indices, source use
//     ex_*         execute-stage instruction: valid, load, mul/div, rd, redirect
//     md_done      multi-cycle result ready (single-cycle pulse)
//     pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush
//                  pipeline hold / bubble controls (combinational)
//     md_start     one-cycle launch pulse to the multi-cycle unit
//     md_busy      high while the FSM sits in MD_WAIT (also the state view)
//     stall_cnt    cycles with pc_stall asserted, wraps
//     flush_cnt    accepted redirects, wraps
//
//   Handshake: md_start is a single-cycle request; the multi-cycle unit
//   answers with a single-cycle md_done, which is only honoured in MD_WAIT.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_is_md,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             md_done,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu_hazard;
    logic redirect;
    logic md_req;
    logic md_fin;
    logic flush_acc;

`ifdef HAZARD_MULDIV_EN
    assign md_req = ex_valid & ex_is_md;
    assign md_fin = md_done;
`else
    // Feature absent: never request, and any stray MD_WAIT exits at once.
    logic unused_md;
    assign unused_md = ex_is_md ^ md_done;
    assign md_req    = 1'b0;
    assign md_fin    = 1'b1;
`endif

    // x0 is hardwired zero, so a load targeting it can never create a hazard.
    assign lu_hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign redirect = ex_valid & ex_redirect;

    always_comb begin
        state_d    = state_q;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_stall = 1'b0;
        idex_flush = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        flush_acc  = 1'b0;

        if (rst) begin
            // Everything quiet during reset; an in-flight wait is abandoned.
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Priority: redirect > mul/div launch > load-use.
                    if (redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_acc  = 1'b1;
                    end else if (md_req) begin
                        md_start   = 1'b1;
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                        state_d    = ST_MD_WAIT;
                    end else if (lu_hazard) begin
                        // Hold IF/ID, insert a bubble into EX; purely
                        // combinational so the stall lasts exactly as long
                        // as the hazard does.
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    // Redirects and load-use are ignored while waiting.
                    md_busy = 1'b1;
                    if (md_fin) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counters read as zero for the whole time reset is held, including the
    // first reset cycle before the registers have cleared.
    assign stall_cnt = rst ? '0 : stall_cnt_q;
    assign flush_cnt = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_valid, ex_is_load, ex_is_md;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        md_done;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic        md_start, md_busy;
    logic [31:0] stall_cnt, flush_cnt;

    logic        w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall, w_idex_flush;
    logic        w_md_start, w_md_busy;
    logic [3:0]  w_stall_cnt, w_flush_cnt;

    logic [6:0]  ctrl;
    assign ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, md_start, md_busy};

    int checks;
    int errors;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_is_md(ex_is_md), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .md_done(md_done), .pc_stall(pc_stall),
        .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
        .idex_flush(idex_flush), .md_start(md_start), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_is_md(ex_is_md), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .md_done(md_done), .pc_stall(w_pc_stall),
        .ifid_stall(w_ifid_stall), .ifid_flush(w_ifid_flush), .idex_stall(w_idex_stall),
        .idex_flush(w_idex_flush), .md_start(w_md_start), .md_busy(w_md_busy),
        .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    // exp order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, md_start, md_busy}
    typedef struct {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic       ld;
        logic [4:0] rd;
        logic       redir;
        logic [6:0] exp;
        logic       finc;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    function automatic vec_t mk(logic idv, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic exv, logic ld, logic [4:0] rd, logic redir,
                                logic [6:0] exp, logic finc);
        vec_t v;
        v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.ld = ld; v.rd = rd; v.redir = redir; v.exp = exp; v.finc = finc;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_is_md = 0; ex_rd = 0; ex_redirect = 0; md_done = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        id_valid = 1; id_rs1 = r; id_uses_rs1 = 1;
        ex_valid = 1; ex_is_load = 1; ex_rd = r;
    endtask

    // Drive one reset cycle with noisy inputs and check the reset view.
    task automatic do_reset(input string nm);
        set_lu(5'd9); ex_redirect = 1; ex_is_md = 1; md_done = 1;
        rst = 1;
        @(negedge clk);
        chk({nm, "_ctrl"}, {25'd0, ctrl}, 32'd0);
        chk({nm, "_scnt"}, stall_cnt, 32'd0);
        chk({nm, "_fcnt"}, flush_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        idle();
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
        checks = 0;
        errors = 0;
        idle();
        rst = 1;
        #1;

        // Fill table: RUN-state single-cycle patterns.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 7'b0000000, 0); // idle
        vecs[1]  = mk(1, 5, 3, 1, 0, 1, 1, 5,  0, 7'b1100100, 0); // LU on rs1
        vecs[2]  = mk(1, 0, 3, 1, 0, 1, 1, 0,  0, 7'b0000000, 0); // load to x0
        vecs[3]  = mk(1, 2, 7, 0, 1, 1, 1, 7,  0, 7'b1100100, 0); // LU on rs2
        vecs[4]  = mk(1, 2, 7, 0, 0, 1, 1, 7,  0, 7'b0000000, 0); // rs2 not used
        vecs[5]  = mk(1, 5, 3, 1, 1, 1, 0, 5,  0, 7'b0000000, 0); // not a load
        vecs[6]  = mk(0, 5, 3, 1, 1, 1, 1, 5,  0, 7'b0000000, 0); // decode empty
        vecs[7]  = mk(1, 5, 3, 1, 1, 0, 1, 5,  0, 7'b0000000, 0); // EX empty
        vecs[8]  = mk(1, 5, 3, 1, 0, 1, 1, 5,  1, 7'b0010100, 1); // redirect beats LU
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 7'b0000000, 0); // redirect, EX empty
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 4,  1, 7'b0010100, 1); // plain redirect
        vecs[11] = mk(1, 6, 8, 0, 1, 1, 1, 6,  0, 7'b0000000, 0); // rs1 match unused

        @(posedge clk); #1;
        do_reset("rst0");

        // Table sweep.
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < NV; i++) begin
            id_valid = vecs[i].idv; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_valid = vecs[i].exv; ex_is_load = vecs[i].ld; ex_rd = vecs[i].rd;
            ex_redirect = vecs[i].redir;
            @(negedge clk);
            chk($sformatf("vec%0d_ctrl", i), {25'd0, ctrl}, {25'd0, vecs[i].exp});
            exp_stall = exp_stall + {31'd0, vecs[i].exp[6]};
            exp_flush = exp_flush + {31'd0, vecs[i].finc};
            next_cycle();
            chk($sformatf("vec%0d_scnt", i), stall_cnt, exp_stall);
            chk($sformatf("vec%0d_fcnt", i), flush_cnt, exp_flush);
        end
        idle();

        // Single-cycle load-use from reset: exactly one stall cycle, no bubble after.
        do_reset("rst1");
        set_lu(5'd5);
        @(negedge clk);
        chk("lu1_ctrl", {25'd0, ctrl}, 32'h64);
        next_cycle();
        idle();
        @(negedge clk);
        chk("lu1_after_ctrl", {25'd0, ctrl}, 32'd0);
        chk("lu1_scnt", stall_cnt, 32'd1);
        next_cycle();

        // Load to x0: no stall.
        do_reset("rst2");
        set_lu(5'd0);
        @(negedge clk);
        chk("lu0_ctrl", {25'd0, ctrl}, 32'd0);
        next_cycle();
        idle();
        chk("lu0_scnt", stall_cnt, 32'd0);

`ifdef HAZARD_MULDIV_EN
        // Mul/div: launch at cycle 0, done at cycle 4.
        do_reset("rst3");
        ex_valid = 1; ex_is_md = 1;
        @(negedge clk);
        chk("md_c0_ctrl", {25'd0, ctrl}, 32'h6A);
        next_cycle();
        idle();
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                set_lu(5'd3); ex_redirect = 1; md_done = 0;
            end else begin
                idle();
            end
            @(negedge clk);
            chk($sformatf("md_c%0d_ctrl", c), {25'd0, ctrl}, 32'h69);
            next_cycle();
        end
        idle();
        md_done = 1;
        @(negedge clk);
        chk("md_c4_ctrl", {25'd0, ctrl}, 32'h01);
        next_cycle();
        // md_done in RUN is ignored.
        @(negedge clk);
        chk("md_c5_ctrl", {25'd0, ctrl}, 32'd0);
        chk("md_scnt", stall_cnt, 32'd4);
        next_cycle();
        idle();
        @(negedge clk);
        chk("md_c6_busy", {31'd0, md_busy}, 32'd0);
        next_cycle();

        // Reset during MD_WAIT abandons the wait.
        do_reset("rst4");
        ex_valid = 1; ex_is_md = 1;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        chk("mdr_wait_ctrl", {25'd0, ctrl}, 32'h69);
        next_cycle();
        rst = 1;
        @(negedge clk);
        chk("mdr_rst_ctrl", {25'd0, ctrl}, 32'd0);
        chk("mdr_rst_scnt", stall_cnt, 32'd0);
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("mdr_post_ctrl", {25'd0, ctrl}, 32'd0);
        chk("mdr_post_scnt", stall_cnt, 32'd0);
        next_cycle();
        ex_valid = 1; ex_is_md = 1;
        @(negedge clk);
        chk("mdr_fresh_ctrl", {25'd0, ctrl}, 32'h6A);
        next_cycle();
        idle();
        @(negedge clk);
        chk("mdr_fresh_busy", {25'd0, ctrl}, 32'h69);
        md_done = 1;
        next_cycle();
        idle();
`else
        // Feature absent: mul/div requests and completions are ignored.
        do_reset("rst3");
        ex_valid = 1; ex_is_md = 1;
        @(negedge clk);
        chk("nomd_c0_ctrl", {25'd0, ctrl}, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("nomd_c1_ctrl", {25'd0, ctrl}, 32'd0);
        next_cycle();
        md_done = 1;
        @(negedge clk);
        chk("nomd_done_ctrl", {25'd0, ctrl}, 32'd0);
        next_cycle();
        idle();
        // Load-use still works right after an ignored ex_is_md.
        set_lu(5'd12); ex_is_md = 1;
        @(negedge clk);
        chk("nomd_lu_ctrl", {25'd0, ctrl}, 32'h64);
        next_cycle();
        idle();
        chk("nomd_scnt", stall_cnt, 32'd1);
`endif

        // Counter wrap: 16 redirects on a 4-bit counter.
        do_reset("rst5");
        ex_valid = 1; ex_redirect = 1;
        for (int k = 0; k < 15; k++) next_cycle();
        chk("wrap15_fcnt4", {28'd0, w_flush_cnt}, 32'd15);
        next_cycle();
        idle();
        chk("wrap16_fcnt4", {28'd0, w_flush_cnt}, 32'd0);
        chk("wrap16_fcnt32", flush_cnt, 32'd16);
        chk("wrap16_scnt4", {28'd0, w_stall_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
